// File: rtl/pacman_pkg.sv
// Shared types for Pac-Man motion: headings, FSM states, HID key codes.
package pacman_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_A  = 3'd1,
    REQ_B  = 3'd2,
    CUR_A  = 3'd3,
    CUR_B  = 3'd4,
    COMMIT = 3'd5
  } state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  function automatic dir_t key_to_dir(input logic [7:0] key);
    case (key)
      KEY_W:   return UP;
      KEY_A:   return LEFT;
      KEY_S:   return DOWN;
      KEY_D:   return RIGHT;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/move_probe_gen.sv
// Leading-edge probe point for a one-step move of the square hitbox.
// sel_b picks the second corner of the leading edge.
import pacman_pkg::*;

module move_probe_gen #(
  parameter int PAC_HALF = 6,
  parameter int STEP     = 1
) (
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  dir_t       i_dir,
  input  logic       i_sel_b,
  output logic [9:0] o_px,
  output logic [9:0] o_py
);

  localparam logic [9:0] LEAD = 10'(PAC_HALF + STEP);
  localparam logic [9:0] SIDE = 10'(PAC_HALF);

  always_comb begin
    o_px = i_x;
    o_py = i_y;
    case (i_dir)
      RIGHT: begin
        o_px = i_x + LEAD;
        o_py = i_sel_b ? (i_y + SIDE) : (i_y - SIDE);
      end
      LEFT: begin
        o_px = i_x - LEAD;
        o_py = i_sel_b ? (i_y + SIDE) : (i_y - SIDE);
      end
      UP: begin
        o_px = i_sel_b ? (i_x + SIDE) : (i_x - SIDE);
        o_py = i_y - LEAD;
      end
      DOWN: begin
        o_px = i_sel_b ? (i_x + SIDE) : (i_x - SIDE);
        o_py = i_y + LEAD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pacman_motion.sv
// Per-frame Pac-Man mover: probes the wall map at the leading edge, tries the
// buffered turn first, falls back to the current heading, then commits one step.
import pacman_pkg::*;

module pacman_motion #(
  parameter logic [9:0] START_X  = 10'd175,
  parameter logic [9:0] START_Y  = 10'd63,
  parameter int         PAC_HALF = 6,
  parameter int         STEP     = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic [9:0] query_x,
  output logic [9:0] query_y,
  input  logic       query_wall,
  output logic [9:0] PacX,
  output logic [9:0] PacY,
  output logic [2:0] dir,
  output logic       moving,
  output logic       busy,
  output logic       tick_overrun
);

  localparam logic [9:0] STEP_V = 10'(STEP);

  state_t     r_state;
  dir_t       r_dir, r_pending, r_move;
  logic [9:0] r_x, r_y, r_qx, r_qy;
  logic       r_tick, r_moving, r_busy, r_overrun;

  dir_t       w_key_dir;
  dir_t       w_pdir [4];
  logic [3:0][9:0] w_px, w_py;

  assign w_key_dir = key_to_dir(keycode);

  // Probe slots 0/1 cover the pending turn, 2/3 the current heading (A/B corners).
  for (genvar g = 0; g < 4; g++) begin : g_probe
    assign w_pdir[g] = (g < 2) ? r_pending : r_dir;
    move_probe_gen #(.PAC_HALF(PAC_HALF), .STEP(STEP)) u_probe (
      .i_x    (r_x),
      .i_y    (r_y),
      .i_dir  (w_pdir[g]),
      .i_sel_b(1'(g % 2)),
      .o_px   (w_px[g]),
      .o_py   (w_py[g])
    );
  end

  // The query register is loaded with the probe of the state being entered,
  // so query_wall is valid during that state's own cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_dir     <= NONE;
      r_pending <= NONE;
      r_move    <= NONE;
      r_x       <= START_X;
      r_y       <= START_Y;
      r_qx      <= '0;
      r_qy      <= '0;
      r_tick    <= 1'b0;
      r_moving  <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_tick    <= frame_tick;
      r_overrun <= r_tick && (r_state != IDLE);
      case (r_state)
        IDLE: if (r_tick) begin
          r_busy <= 1'b1;
          if (r_pending != NONE) begin
            r_state <= REQ_A; r_qx <= w_px[0]; r_qy <= w_py[0];
          end else if (r_dir != NONE) begin
            r_state <= CUR_A; r_qx <= w_px[2]; r_qy <= w_py[2];
          end else begin
            r_state <= COMMIT; r_move <= NONE;
          end
        end
        REQ_A, REQ_B: begin
          if (query_wall) begin
            if (r_dir != NONE) begin
              r_state <= CUR_A; r_qx <= w_px[2]; r_qy <= w_py[2];
            end else begin
              r_state <= COMMIT; r_move <= NONE;
            end
          end else if (r_state == REQ_A) begin
            r_state <= REQ_B; r_qx <= w_px[1]; r_qy <= w_py[1];
          end else begin
            r_state   <= COMMIT;
            r_move    <= r_pending;
            r_dir     <= r_pending;
            r_pending <= NONE;
          end
        end
        CUR_A: begin
          if (query_wall) begin
            r_state <= COMMIT; r_move <= NONE;
          end else begin
            r_state <= CUR_B; r_qx <= w_px[3]; r_qy <= w_py[3];
          end
        end
        CUR_B: begin
          r_state <= COMMIT;
          r_move  <= query_wall ? NONE : r_dir;
        end
        COMMIT: begin
          case (r_move)
            UP:      r_y <= r_y - STEP_V;
            DOWN:    r_y <= r_y + STEP_V;
            LEFT:    r_x <= r_x - STEP_V;
            RIGHT:   r_x <= r_x + STEP_V;
            default: ;
          endcase
          r_moving <= (r_move != NONE);
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A live key overrides the post-commit clear so a held key stays buffered.
      if (w_key_dir != NONE) r_pending <= w_key_dir;
    end
  end

  assign query_x      = r_qx;
  assign query_y      = r_qy;
  assign PacX         = r_x;
  assign PacY         = r_y;
  assign dir          = r_dir;
  assign moving       = r_moving;
  assign busy         = r_busy;
  assign tick_overrun = r_overrun;

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion with a small maze model on the query port.
import pacman_pkg::*;

module tb_pacman_motion;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] query_x, query_y;
  logic       query_wall;
  logic [9:0] PacX, PacY;
  logic [2:0] dir;
  logic       moving, busy, tick_overrun;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  pacman_motion dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .keycode     (keycode),
    .query_x     (query_x),
    .query_y     (query_y),
    .query_wall  (query_wall),
    .PacX        (PacX),
    .PacY        (PacY),
    .dir         (dir),
    .moving      (moving),
    .busy        (busy),
    .tick_overrun(tick_overrun)
  );

  // Maze model: outer wall band around an open field.
  function automatic logic is_wall(input logic [9:0] x, input logic [9:0] y);
    return (x <= 10'd162) || (y <= 10'd50) || (x >= 10'd600) || (y >= 10'd440);
  endfunction

  assign query_wall = is_wall(query_x, query_y);

  typedef struct {
    logic       rst;
    logic [7:0] key;
    logic [9:0] ex;
    logic [9:0] ey;
    logic [2:0] edir;
    logic       emov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [7:0] key, input int ex, input int ey,
                              input dir_t edir, input logic emov);
    vec_t v;
    v.rst = rst; v.key = key; v.ex = 10'(ex); v.ey = 10'(ey); v.edir = edir; v.emov = emov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; frame_tick = 1'b0; keycode = 8'h00;
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("rst_x", PacX, 175);
      chk("rst_y", PacY, 63);
      chk("rst_dir", dir, NONE);
      chk("rst_mov", moving, 0);
      chk("rst_busy", busy, 0);
    end
    chk("rst_qx", query_x, 0);
    chk("rst_ovr", tick_overrun, 0);
    Reset = 1'b0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stimulus table: reset rows, then one frame per row with expected state after it.
    tbl.push_back(mk(1, 8'h00, 175, 63, NONE, 0));
    tbl.push_back(mk(0, 8'h00, 175, 63, NONE, 0));
    tbl.push_back(mk(0, KEY_S, 175, 64, DOWN, 1));
    tbl.push_back(mk(0, 8'h05, 175, 65, DOWN, 1));
    tbl.push_back(mk(1, 8'h00, 175, 63, NONE, 0));
    for (int i = 1; i <= 6; i++) tbl.push_back(mk(0, KEY_A, 175 - i, 63, LEFT, 1));
    tbl.push_back(mk(0, KEY_A, 169, 63, LEFT, 0));
    tbl.push_back(mk(0, KEY_A, 169, 63, LEFT, 0));
    tbl.push_back(mk(1, 8'h00, 175, 63, NONE, 0));
    for (int i = 1; i <= 6; i++) tbl.push_back(mk(0, KEY_W, 175, 63 - i, UP, 1));
    tbl.push_back(mk(0, KEY_W, 175, 57, UP, 0));
    tbl.push_back(mk(0, KEY_W, 175, 57, UP, 0));
    for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, KEY_D, 175 + i, 57, RIGHT, 1));
    tbl.push_back(mk(0, KEY_W, 181, 57, RIGHT, 1));
    tbl.push_back(mk(0, 8'h00, 182, 57, RIGHT, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        keycode = tbl[i].key;
        step(1);
        pulse_tick();
        step(8);
        chk($sformatf("v%0d_x", i), PacX, tbl[i].ex);
        chk($sformatf("v%0d_y", i), PacY, tbl[i].ey);
        chk($sformatf("v%0d_dir", i), dir, tbl[i].edir);
        chk($sformatf("v%0d_mov", i), moving, tbl[i].emov);
        chk($sformatf("v%0d_busy", i), busy, 0);
      end
    end

    // Buffered UP still pending: fallback path commits later than a clear turn.
    keycode = 8'h00;
    step(1);
    pulse_tick();
    step(4);
    chk("pend_k4_x", PacX, 182);
    chk("pend_k4_busy", busy, 1);
    step(2);
    chk("pend_k6_x", PacX, 183);
    chk("pend_k6_dir", dir, RIGHT);

    // Clear turn latency from reset.
    do_reset();
    keycode = KEY_D;
    step(1);
    pulse_tick();
    step(2);
    chk("lat_k2_busy", busy, 1);
    step(1);
    chk("lat_k3_x", PacX, 175);
    step(1);
    chk("lat_k4_x", PacX, 176);
    chk("lat_k4_dir", dir, RIGHT);
    chk("lat_k4_mov", moving, 1);
    step(1);
    chk("lat_k5_busy", busy, 0);

    // Tick during REQ_B: overrun pulse, single step.
    do_reset();
    keycode = KEY_D;
    step(1);
    pulse_tick();
    step(2);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("ovr_k3", tick_overrun, 0);
    step(1);
    chk("ovr_k4", tick_overrun, 1);
    chk("ovr_k4_x", PacX, 176);
    step(1);
    chk("ovr_k5", tick_overrun, 0);
    keycode = 8'h00;
    step(10);
    chk("ovr_one_step", PacX, 176);
    chk("ovr_busy", busy, 0);

    // Reset while probing the current heading aborts without commit.
    do_reset();
    keycode = KEY_W;
    step(1);
    pulse_tick();
    keycode = 8'h00;
    step(6);
    chk("abort_pre_y", PacY, 62);
    chk("abort_pre_dir", dir, UP);
    pulse_tick();
    step(1);
    chk("abort_busy_in", busy, 1);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    chk("abort_x", PacX, 175);
    chk("abort_y", PacY, 63);
    chk("abort_dir", dir, NONE);
    chk("abort_busy", busy, 0);
    step(8);
    chk("abort_hold_y", PacY, 63);
    chk("abort_hold_mov", moving, 0);
    chk("abort_hold_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
